char_anim_sequencer: RTL and testbench



---
 rtl/char_anim_sequencer.sv | 172 +++++++++++++++++
 tb/tb_char_anim_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/char_anim_sequencer.sv
// char_anim_sequencer: per-tick player animation sequencer.
// Maps physics state and vertical velocity to animation ID, frame index and
// mirror flag. Landing type is chosen from the peak downward speed seen while
// airborne. LAND and BUMP animations are timed holds that nothing but reset
// can interrupt; anim_done pulses when a hold expires.
// Optional macro CHAR_ANIM_CHARGE_LEVEL_EN: CHARGE steps a saturating charge
// meter through frame_idx instead of showing a single static frame.
`timescale 1ns/1ps
module char_anim_sequencer #(
    parameter int SIGNED_PHY_WIDTH  = 15,
    parameter int FRAME_W           = 3,
    parameter int CNT_W             = 6,
    parameter int IDLE_FRAMES       = 2,
    parameter int WALK_FRAMES       = 4,
    parameter int CHARGE_FRAMES     = 4,
    parameter int FRAME_TICKS       = 16,
    parameter int CHARGE_STEP_TICKS = 8,
    parameter int LAND_TICKS        = 32,
    parameter int BUMP_TICKS        = 8,
    parameter int HARD_LAND_VEL     = 5
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        frame_tick,
    input  logic [2:0]                  char_state,
    input  logic [SIGNED_PHY_WIDTH-1:0] vel_y,
    output logic [2:0]                  anim_id,
    output logic [FRAME_W-1:0]          frame_idx,
    output logic                        mirror,
    output logic                        anim_done
);
    localparam int W = SIGNED_PHY_WIDTH;

    // Physics states
    localparam logic [2:0] S_IDLE = 3'd0, S_LEFT = 3'd1, S_RIGHT = 3'd2, S_CHARGE = 3'd3,
                           S_JUMP = 3'd4, S_COLL = 3'd5, S_FALL  = 3'd6, S_HOLD   = 3'd7;
    // Animation IDs
    localparam logic [2:0] A_IDLE = 3'd0, A_WALK = 3'd1, A_CHARGE = 3'd2, A_JUP  = 3'd3,
                           A_JDN  = 3'd4, A_HARD = 3'd5, A_SOFT   = 3'd6, A_BUMP = 3'd7;

    localparam logic [CNT_W-1:0]   FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0]   LAND_LAST  = CNT_W'(LAND_TICKS - 1);
    localparam logic [CNT_W-1:0]   BUMP_LAST  = CNT_W'(BUMP_TICKS - 1);
    localparam logic [FRAME_W-1:0] IDLE_LAST  = FRAME_W'(IDLE_FRAMES - 1);
    localparam logic [FRAME_W-1:0] WALK_LAST  = FRAME_W'(WALK_FRAMES - 1);
    localparam logic [W-1:0]       HARD_VEL   = W'(HARD_LAND_VEL);
    localparam logic [W-1:0]       VEL_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]       VEL_MAX    = {1'b0, {(W-1){1'b1}}};

    logic             tick_r;
    logic [2:0]       state_r;
    logic [W-1:0]     vel_r;
    logic [W-1:0]     peak_fall;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] hold_cnt;

    logic             vel_neg, vel_pos;
    logic [W-1:0]     fall_mag;
    logic             is_land, in_hold, hold_stay, expire;
    logic [CNT_W-1:0] hold_last;
    logic [2:0]       idle_rule, next_anim;
    logic             anim_chg, clr_peak;

    // Register the tick and physics inputs once
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_r  <= 1'b0;
            state_r <= '0;
            vel_r   <= '0;
        end else begin
            tick_r  <= frame_tick;
            state_r <= char_state;
            vel_r   <= vel_y;
        end
    end

    // Velocity decode; negating the most negative value saturates
    always_comb begin
        vel_neg  = vel_r[W-1];
        vel_pos  = !vel_r[W-1] && (vel_r != '0);
        fall_mag = (vel_r == VEL_MIN) ? VEL_MAX : (~vel_r + 1'b1);
    end

    // Hold bookkeeping and next-animation priority selection
    always_comb begin
        is_land   = (anim_id == A_HARD) || (anim_id == A_SOFT);
        in_hold   = is_land || (anim_id == A_BUMP);
        hold_last = is_land ? LAND_LAST : BUMP_LAST;
        hold_stay = in_hold && (hold_cnt < hold_last);
        expire    = in_hold && !hold_stay;
        idle_rule = vel_pos ? A_JUP : (vel_neg ? A_JDN : A_IDLE);
        next_anim = idle_rule;
        if (hold_stay) begin
            next_anim = anim_id;
        end else begin
            case (state_r)
                S_COLL:  next_anim = (anim_id != A_BUMP) ? A_BUMP : idle_rule;
                S_FALL: begin
                    if (anim_id == A_JUP || anim_id == A_JDN || anim_id == A_BUMP)
                        next_anim = (peak_fall > HARD_VEL) ? A_HARD : A_SOFT;
                    else
                        next_anim = idle_rule;
                end
                S_JUMP:  next_anim = vel_neg ? A_JDN : A_JUP;
                S_LEFT, S_RIGHT: next_anim = A_WALK;
                S_CHARGE: next_anim = A_CHARGE;
                default: next_anim = idle_rule;
            endcase
        end
        anim_chg = (next_anim != anim_id);
        clr_peak = anim_chg && (next_anim == A_HARD || next_anim == A_SOFT ||
                                next_anim == A_IDLE || next_anim == A_WALK ||
                                next_anim == A_CHARGE);
    end

    // Per-tick state update: animation, counters, frame, mirror, peak fall
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            anim_id   <= A_IDLE;
            frame_idx <= '0;
            mirror    <= 1'b0;
            anim_done <= 1'b0;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
            peak_fall <= '0;
        end else begin
            anim_done <= 1'b0;
            if (tick_r) begin
                anim_done <= expire;
                anim_id   <= next_anim;
                if (anim_chg) begin
                    frame_idx <= '0;
                    tick_cnt  <= '0;
                    hold_cnt  <= '0;
                end else if (hold_stay) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end else if (anim_id == A_IDLE || anim_id == A_WALK) begin
                    if (tick_cnt == FRAME_LAST) begin
                        tick_cnt <= '0;
                        if (frame_idx == ((anim_id == A_IDLE) ? IDLE_LAST : WALK_LAST))
                            frame_idx <= '0;
                        else
                            frame_idx <= frame_idx + 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`ifdef CHAR_ANIM_CHARGE_LEVEL_EN
                else if (anim_id == A_CHARGE) begin
                    if (tick_cnt == CNT_W'(CHARGE_STEP_TICKS - 1)) begin
                        tick_cnt <= '0;
                        if (frame_idx != FRAME_W'(CHARGE_FRAMES - 1))
                            frame_idx <= frame_idx + 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`else
                // CHARGE is a single static frame in this build
`endif
                if (!hold_stay) begin
                    if (state_r == S_LEFT)       mirror <= 1'b1;
                    else if (state_r == S_RIGHT) mirror <= 1'b0;
                end
                if (clr_peak)
                    peak_fall <= '0;
                else if (vel_neg && (fall_mag > peak_fall))
                    peak_fall <= fall_mag;
            end
        end
    end
endmodule

// File: tb/tb_char_anim_sequencer.sv
// Directed self-checking bench for char_anim_sequencer.
`timescale 1ns/1ps
module tb_char_anim_sequencer;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [2:0]  char_state = 3'd0;
    logic [14:0] vel_y = '0;
    logic [2:0]  anim_id;
    logic [2:0]  frame_idx;
    logic        mirror;
    logic        anim_done;

    int n_chk = 0;
    int n_err = 0;

    char_anim_sequencer dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_tick(frame_tick),
        .char_state(char_state), .vel_y(vel_y), .anim_id(anim_id),
        .frame_idx(frame_idx), .mirror(mirror), .anim_done(anim_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One tick pulse; returns at the negedge where its result is visible
    task automatic tk(input logic [2:0] st, input int v);
        @(negedge sys_clk);
        char_state = st;
        vel_y      = 15'(v);
        frame_tick = 1'b1;
        @(negedge sys_clk);
        frame_tick = 1'b0;
        @(negedge sys_clk);
    endtask

    // n more ticks held in exp_anim, then expiry to IDLE with anim_done
    task automatic hold_run(input logic [2:0] st, input logic [2:0] exp_anim, input int n);
        for (int i = 0; i < n; i++) begin
            tk(st, 0);
            chk("hold_anim", 32'(anim_id), 32'(exp_anim));
            chk("hold_done", 32'(anim_done), 0);
        end
        tk(st, 0);
        chk("expire_anim", 32'(anim_id), 0);
        chk("expire_done", 32'(anim_done), 1);
        @(negedge sys_clk);
        chk("done_clear", 32'(anim_done), 0);
    endtask

    initial begin
        #12;
        chk("rst_anim", 32'(anim_id), 0);
        chk("rst_frame", 32'(frame_idx), 0);
        chk("rst_mirror", 32'(mirror), 0);
        chk("rst_done", 32'(anim_done), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // IDLE loop: frame toggles every 16 ticks
        for (int t = 1; t <= 40; t++) begin
            tk(3'd0, 0);
            chk("idle_anim", 32'(anim_id), 0);
            chk("idle_frame", 32'(frame_idx), (t >= 16 && t < 32) ? 1 : 0);
        end

        // Hard landing: peak 9
        tk(3'd4, 8);  chk("jump_up", 32'(anim_id), 3);
        tk(3'd4, -3); chk("jump_dn1", 32'(anim_id), 4);
        tk(3'd4, -9); chk("jump_dn2", 32'(anim_id), 4);
        tk(3'd6, 0);  chk("hard_land", 32'(anim_id), 5);
        chk("hard_frame", 32'(frame_idx), 0);
        hold_run(3'd6, 3'd5, 31);

        // Soft landing: peak 4
        tk(3'd4, 8);  chk("jump_up_s", 32'(anim_id), 3);
        tk(3'd4, -3); tk(3'd4, -4);
        tk(3'd6, 0);  chk("soft_land", 32'(anim_id), 6);
        hold_run(3'd6, 3'd6, 31);

        // Boundary: peak exactly 5 is soft
        tk(3'd4, -5); chk("jump_dn5", 32'(anim_id), 4);
        tk(3'd6, 0);  chk("soft_eq5", 32'(anim_id), 6);
        hold_run(3'd6, 3'd6, 31);

        // Boundary: peak 6 is hard (peak cleared by previous landing)
        tk(3'd4, -6); tk(3'd6, 0); chk("hard_eq6", 32'(anim_id), 5);
        hold_run(3'd6, 3'd5, 31);

        // Most negative velocity saturates to a hard landing
        tk(3'd4, -16384); chk("jump_min", 32'(anim_id), 4);
        tk(3'd6, 0);      chk("hard_min", 32'(anim_id), 5);
        hold_run(3'd6, 3'd5, 31);

        // HOLD uses the idle rule; JUMP with vel 0 is JUMP_UP
        tk(3'd7, 1);  chk("hold_up", 32'(anim_id), 3);
        tk(3'd7, -1); chk("hold_dn", 32'(anim_id), 4);
        tk(3'd4, 0);  chk("jump_zero", 32'(anim_id), 3);
        tk(3'd7, 0);  chk("hold_idle", 32'(anim_id), 0);
        // FALL_TO_GROUND from IDLE is not a landing
        tk(3'd6, 0);  chk("fall_idle", 32'(anim_id), 0);

        // Walk and mirror
        for (int t = 0; t < 3; t++) begin
            tk(3'd1, 0);
            chk("walk_anim", 32'(anim_id), 1);
            chk("walk_mirror", 32'(mirror), 1);
        end
        tk(3'd0, 0); chk("idle_after_l", 32'(anim_id), 0);
        chk("mirror_held", 32'(mirror), 1);
        tk(3'd2, 0); chk("walk_right", 32'(anim_id), 1);
        chk("mirror_right", 32'(mirror), 0);

        // Collision held: 8 ticks BUMP, expiry to IDLE, BUMP again
        for (int t = 1; t <= 20; t++) begin
            tk(3'd5, 0);
            chk("bump_anim", 32'(anim_id), ((t - 1) % 9 == 8) ? 0 : 7);
            chk("bump_done", 32'(anim_done), ((t - 1) % 9 == 8) ? 1 : 0);
        end
        // Mirror frozen during hold, hold not interrupted by LEFT
        tk(3'd1, 0);
        chk("frz_anim", 32'(anim_id), 7);
        chk("frz_mirror", 32'(mirror), 0);

        // Asynchronous reset mid-hold
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_anim", 32'(anim_id), 0);
        chk("arst_frame", 32'(frame_idx), 0);
        chk("arst_mirror", 32'(mirror), 0);
        chk("arst_done", 32'(anim_done), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tk(3'd0, 0);
        chk("post_rst_anim", 32'(anim_id), 0);
        chk("post_rst_frame", 32'(frame_idx), 0);

        // Charge
        for (int t = 0; t < 40; t++) begin
            tk(3'd3, 0);
            chk("charge_anim", 32'(anim_id), 2);
`ifdef CHAR_ANIM_CHARGE_LEVEL_EN
            chk("charge_frame", 32'(frame_idx), (t / 8 > 3) ? 3 : t / 8);
`else
            chk("charge_frame", 32'(frame_idx), 0);
`endif
        end

        // Back-to-back ticks: BUMP lasts 8 cycles, then a single done pulse
        @(negedge sys_clk);
        char_state = 3'd5;
        vel_y      = '0;
        frame_tick = 1'b1;
        @(negedge sys_clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge sys_clk);
            chk("cont_anim", 32'(anim_id), (c == 9) ? 0 : 7);
            chk("cont_done", 32'(anim_done), (c == 9) ? 1 : 0);
        end
        frame_tick = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
